// File: rtl/result_chk_pkg.sv
// rtl/result_chk_pkg.sv - shared state encoding and width helper for the result checker
package result_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Never returns less than 1, so a degenerate DEPTH still yields a legal vector width.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/result_checker_if.sv
// rtl/result_checker_if.sv - load, control, result stream and status bundle of the result checker
interface result_checker_if
  import result_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = clog2(DEPTH),
  parameter int CW    = clog2(DEPTH + 1)
) ();

  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] ld_mask;
  logic [CW-1:0]    num_vec;
  logic             start;
  logic             stop_on_fail;
  logic             abort;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CW-1:0]    pass_cnt;
  logic [CW-1:0]    fail_cnt;
  logic             fail_seen;
  logic [AW-1:0]    first_fail_idx;
  logic [WIDTH-1:0] first_fail_got;

  modport master (
    output ld_en, ld_addr, ld_data, ld_mask, num_vec, start, stop_on_fail, abort,
           res_valid, res_data,
    input  busy, done, pass, pass_cnt, fail_cnt, fail_seen, first_fail_idx, first_fail_got
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, ld_mask, num_vec, start, stop_on_fail, abort,
           res_valid, res_data,
    output busy, done, pass, pass_cnt, fail_cnt, fail_seen, first_fail_idx, first_fail_got
  );

endinterface

// File: rtl/chk_table.sv
// rtl/chk_table.sv - expected-value/mask table, one synchronous write port, one asynchronous read port
module chk_table #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] rmask
);

  // Contents are deliberately not reset; a run only reads entries the user loaded.
  logic [2*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {wdata, wmask};
  end

  assign {rdata, rmask} = mem[raddr];

endmodule

// File: rtl/result_checker.sv
// rtl/result_checker.sv - compares a qualified result stream against a loaded expected table
module result_checker
  import result_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = clog2(DEPTH),
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  result_checker_if.slave bus
);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic [CW-1:0]    nv_q;
  logic             sof_q;
  logic [CW-1:0]    pass_cnt_q, fail_cnt_q;
  logic             fail_seen_q;
  logic [AW-1:0]    ffi_q;
  logic [WIDTH-1:0] ffg_q;

  logic [WIDTH-1:0] exp_word, mask_word;
  logic             can_load, table_we, start_ok, cmp, mismatch, last;
  logic [CW-1:0]    nv_clamped;

  assign can_load   = (state_q != RUN);
  assign table_we   = bus.ld_en && can_load && (int'(bus.ld_addr) < DEPTH);
  assign start_ok   = bus.start && can_load && !bus.abort;
  assign cmp        = (state_q == RUN) && bus.res_valid && !bus.abort;
  assign mismatch   = |((bus.res_data ^ exp_word) & mask_word);
  assign last       = ((CW'(idx_q) + CW'(1)) == nv_q);
  assign nv_clamped = (int'(bus.num_vec) > DEPTH) ? CW'(DEPTH) : bus.num_vec;

  chk_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .we    (table_we),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .wmask (bus.ld_mask),
    .raddr (idx_q),
    .rdata (exp_word),
    .rmask (mask_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) state_d = (nv_clamped == '0) ? DONE : RUN;
        RUN:        if (bus.res_valid && ((mismatch && sof_q) || last)) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // abort leaves every counter and capture untouched so the partial run can be inspected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      nv_q        <= '0;
      sof_q       <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      ffi_q       <= '0;
      ffg_q       <= '0;
    end else if (start_ok) begin
      idx_q       <= '0;
      nv_q        <= nv_clamped;
      sof_q       <= bus.stop_on_fail;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      ffi_q       <= '0;
      ffg_q       <= '0;
    end else if (cmp) begin
      if (mismatch) begin
        fail_cnt_q <= fail_cnt_q + CW'(1);
        if (!fail_seen_q) begin
          fail_seen_q <= 1'b1;
          ffi_q       <= idx_q;
          ffg_q       <= bus.res_data;
        end
      end else begin
        pass_cnt_q <= pass_cnt_q + CW'(1);
      end
      if (!(mismatch && sof_q)) idx_q <= idx_q + AW'(1);
    end
  end

  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = (state_q == DONE) && (fail_cnt_q == '0) &&
                              ((pass_cnt_q + fail_cnt_q) == nv_q);
  assign bus.pass_cnt       = pass_cnt_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.fail_seen      = fail_seen_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_got = ffg_q;

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - directed bench with a behavioural reference model for result_checker
module tb_result_checker;

  localparam int W = 32;
  localparam int D = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  result_checker_if #(.WIDTH(W), .DEPTH(D)) bus ();

  result_checker #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] vec20 [20] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hb, 32'h3,
                               32'hfffffffe, 32'h0, 32'h5, 32'h1, 32'hfffffff4, 32'h4d2,
                               32'hfffff8d7, 32'h1, 32'hfffffb2c, 32'h30, 32'h30};
  logic [W-1:0] tab [D];

  // Reference model: mode 0 idle, 1 running, 2 finished.
  logic [W-1:0] m_exp [D];
  logic [W-1:0] m_msk [D];
  int           m_mode = 0, m_idx = 0, m_nv = 0, m_pc = 0, m_fc = 0, m_ffi = 0;
  logic         m_sof = 1'b0, m_fs = 1'b0, m_ok;
  logic [W-1:0] m_ffg = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_idx = 0; m_nv = 0; m_sof = 0;
      m_pc = 0; m_fc = 0; m_fs = 0; m_ffi = 0; m_ffg = '0;
    end else begin
      if (m_mode != 1 && bus.ld_en && int'(bus.ld_addr) < D) begin
        m_exp[bus.ld_addr] = bus.ld_data;
        m_msk[bus.ld_addr] = bus.ld_mask;
      end
      if (bus.abort) begin
        m_mode = 0;
      end else if (m_mode != 1) begin
        if (bus.start) begin
          m_pc = 0; m_fc = 0; m_fs = 0; m_ffi = 0; m_ffg = '0; m_idx = 0;
          m_nv   = (int'(bus.num_vec) > D) ? D : int'(bus.num_vec);
          m_sof  = bus.stop_on_fail;
          m_mode = (m_nv == 0) ? 2 : 1;
        end
      end else if (bus.res_valid) begin
        m_ok = (((bus.res_data ^ m_exp[m_idx]) & m_msk[m_idx]) == '0);
        if (m_ok) m_pc++;
        else begin
          m_fc++;
          if (!m_fs) begin
            m_fs = 1; m_ffi = m_idx; m_ffg = bus.res_data;
          end
        end
        if (!m_ok && m_sof) m_mode = 2;
        else begin
          m_idx++;
          if (m_idx == m_nv) m_mode = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_mode == 1));
    chk("done", 64'(bus.done), 64'(m_mode == 2));
    chk("pass", 64'(bus.pass), 64'(m_mode == 2 && m_fc == 0 && m_pc == m_nv));
    chk("pass_cnt", 64'(bus.pass_cnt), 64'(m_pc));
    chk("fail_cnt", 64'(bus.fail_cnt), 64'(m_fc));
    chk("fail_seen", 64'(bus.fail_seen), 64'(m_fs));
    chk("first_fail_idx", 64'(bus.first_fail_idx), 64'(m_ffi));
    chk("first_fail_got", 64'(bus.first_fail_got), 64'(m_ffg));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    bus.ld_en = 1'b1; bus.ld_addr = 5'(a); bus.ld_data = d; bus.ld_mask = m;
    tick();
    bus.ld_en = 1'b0;
  endtask

  task automatic start_run(input int nv, input logic sof);
    bus.start = 1'b1; bus.num_vec = 6'(nv); bus.stop_on_fail = sof;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] v);
    bus.res_valid = 1'b1; bus.res_data = v;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(bus.done), 64'd1);
  endtask

  task automatic run_all_pass(input string name);
    start_run(20, 1'b0);
    for (int i = 0; i < 20; i++) feed(tab[i]);
    wait_done({name, "_done"});
    chk({name, "_pass_cnt"}, 64'(bus.pass_cnt), 64'd20);
    chk({name, "_pass"}, 64'(bus.pass), 64'd1);
  endtask

  initial begin
    bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_mask = '0;
    bus.num_vec = '0; bus.start = 0; bus.stop_on_fail = 0; bus.abort = 0;
    bus.res_valid = 0; bus.res_data = '0;
    for (int i = 0; i < D; i++) tab[i] = (i < 20) ? vec20[i] : W'(i * 7 + 3);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass_cnt", 64'(bus.pass_cnt), 64'd0);

    for (int i = 0; i < 20; i++) load(i, vec20[i], '1);
    run_all_pass("allpass");
    chk("allpass_fail_cnt", 64'(bus.fail_cnt), 64'd0);

    start_run(20, 1'b0);
    for (int i = 0; i < 20; i++) feed((i == 9) ? 32'hfffffffd : tab[i]);
    wait_done("runall_done");
    chk("runall_pass_cnt", 64'(bus.pass_cnt), 64'd19);
    chk("runall_fail_cnt", 64'(bus.fail_cnt), 64'd1);
    chk("runall_ffi", 64'(bus.first_fail_idx), 64'd9);
    chk("runall_ffg", 64'(bus.first_fail_got), 64'hfffffffd);
    chk("runall_pass", 64'(bus.pass), 64'd0);

    start_run(20, 1'b1);
    for (int i = 0; i < 10; i++) feed((i == 9) ? 32'hfffffffd : tab[i]);
    chk("sof_done", 64'(bus.done), 64'd1);
    chk("sof_pass_cnt", 64'(bus.pass_cnt), 64'd9);
    chk("sof_fail_cnt", 64'(bus.fail_cnt), 64'd1);
    feed(tab[10]);
    chk("sof_hold_pass_cnt", 64'(bus.pass_cnt), 64'd9);
    chk("sof_hold_fail_cnt", 64'(bus.fail_cnt), 64'd1);

    load(0, 32'h000004d2, 32'hffffff00);
    tab[0] = 32'h000004d2;
    start_run(3, 1'b0);
    feed(32'h000004ff);
    repeat (3) tick();
    chk("gap_busy", 64'(bus.busy), 64'd1);
    chk("gap_pass_cnt", 64'(bus.pass_cnt), 64'd1);
    feed(tab[1]);
    repeat (3) tick();
    feed(tab[2]);
    chk("gap_done", 64'(bus.done), 64'd1);
    chk("gap_pass_cnt_final", 64'(bus.pass_cnt), 64'd3);
    chk("gap_pass", 64'(bus.pass), 64'd1);

    start_run(0, 1'b0);
    chk("nv0_done", 64'(bus.done), 64'd1);
    chk("nv0_pass", 64'(bus.pass), 64'd1);

    for (int i = 20; i < D; i++) load(i, tab[i], '1);
    start_run(D + 5, 1'b0);
    for (int i = 0; i < D; i++) begin
      if (i == 10) begin
        bus.start = 1'b1; bus.num_vec = 6'd3;
        bus.ld_en = 1'b1; bus.ld_addr = 5'd31; bus.ld_data = 32'hdead; bus.ld_mask = '1;
      end
      feed(tab[i]);
      bus.start = 1'b0; bus.ld_en = 1'b0;
    end
    chk("clamp_done", 64'(bus.done), 64'd1);
    chk("clamp_pass_cnt", 64'(bus.pass_cnt), 64'd32);
    chk("clamp_pass", 64'(bus.pass), 64'd1);

    start_run(20, 1'b0);
    for (int i = 0; i < 5; i++) feed(tab[i]);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    run_all_pass("after_rst");

    start_run(20, 1'b0);
    for (int i = 0; i < 5; i++) feed(tab[i]);
    bus.abort = 1'b1; bus.res_valid = 1'b1; bus.res_data = tab[5];
    tick();
    bus.abort = 1'b0; bus.res_valid = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_pass_cnt", 64'(bus.pass_cnt), 64'd5);
    run_all_pass("after_abort");
    chk("after_abort_fail_seen", 64'(bus.fail_seen), 64'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Synthesizable, parametrised result checker for processor bring-up.
- Stores a table of expected result words with per-entry compare masks, then compares a live result stream (e.g. processor Result, qualified by a valid strobe) against that table in order.
- Counts passes and fails, captures the first mismatch, and offers a run-all or stop-on-first-fail mode.
- Sits beside the processor core in simulation and FPGA builds, replacing hand-timed per-cycle checks.

Parameters:
- WIDTH, 32, result/expected word width in bits
- DEPTH, 32, maximum number of expected entries
- AW, $clog2(DEPTH), table address width (derived)
- CW, $clog2(DEPTH+1), counter width (derived)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_en  in  1  write one table entry this cycle
- ld_addr  in  AW  table entry index
- ld_data  in  WIDTH  expected value
- ld_mask  in  WIDTH  compare mask; 1 = bit checked
- num_vec  in  CW  number of entries to check; sampled on start
- start  in  1  begin a check run (single-cycle pulse)
- stop_on_fail  in  1  mode; sampled on start
- abort  in  1  return to IDLE, keep counters
- res_valid  in  1  res_data valid this cycle
- res_data  in  WIDTH  result under test
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  done, fail_cnt==0, and checked==num_vec
- pass_cnt  out  CW  matching results
- fail_cnt  out  CW  mismatching results
- fail_seen  out  1  at least one mismatch this run
- first_fail_idx  out  AW  index of first mismatch
- first_fail_got  out  WIDTH  res_data at first mismatch

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, index=0, all outputs 0. Table contents are not reset; entries are undefined until loaded.
- States: IDLE, RUN, DONE.
- IDLE / DONE:
  - ld_en writes {ld_data, ld_mask} at ld_addr on the clock edge.
  - ld_addr >= DEPTH is ignored.
- RUN: ld_en is ignored.
- Start (accepted only in IDLE or DONE):
  - Clears pass_cnt, fail_cnt, fail_seen, first_fail_*, and index.
  - Latches nv = min(num_vec, DEPTH) and stop_on_fail.
  - nv==0: go to DONE; pass=1 the next cycle.
  - Otherwise: go to RUN.
  - start during RUN is ignored.
- Compare (RUN, res_valid=1):
  - match when ((res_data ^ exp[index]) & mask[index]) == 0.
  - Counters update on the same edge; visible the next cycle (latency 1).
  - res_valid=0 cycles are skipped; index holds.
- First mismatch (fail_seen=0):
  - Capture first_fail_idx=index and first_fail_got=res_data.
  - Set fail_seen=1.
  - Later mismatches only increment fail_cnt.
- Advance: index increments on each compare.
  - The compare at index==nv-1 moves to DONE.
  - stop_on_fail=1 and a mismatch moves to DONE immediately; index is not incremented.
- Write/compare collision: a same-cycle table write cannot collide with a compare because loads are blocked in RUN.
- Counter width: counters never exceed nv, so no saturation is needed.
- abort: from any state, go to IDLE on the next edge; counters and captures are held. abort has priority over start and compare in the same cycle.
- busy/done are decoded from the state register (registered outputs). pass is combinational from registered values.

Decomposition:
- Shared package result_chk_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam widths AW/CW helper function (clog2)
- One natural sub-module: chk_table, a DEPTH x (2*WIDTH) register array with one synchronous write port and one asynchronous read port.
- FSM, counters and capture stay in the top module.

Test Plan:
- All pass: load 20 entries {0,1,2,4,5,7,8,0xb,3,0xfffffffe,0,5,1,0xfffffff4,0x4d2,0xfffff8d7,1,0xfffffb2c,0x30,0x30}, mask all-ones, num_vec=20. Feed identical stream with res_valid=1 -> done after 20 compares; pass_cnt=20, fail_cnt=0, pass=1.
- Run-all mismatch: same table; feed 0xfffffffd at index 9 -> pass_cnt=19, fail_cnt=1, first_fail_idx=9, first_fail_got=0xfffffffd, pass=0.
- Stop-on-fail: as above with stop_on_fail=1 -> done one cycle after the index-9 compare; pass_cnt=9, fail_cnt=1. A further res_valid changes nothing.
- Mask and gaps: entry 0 = 0x000004d2 with mask 0xffffff00, res 0x000004ff -> match. Insert 3 res_valid=0 cycles between compares -> index holds; final counts are unchanged by the gaps.
- Boundaries: num_vec=0 -> done and pass the next cycle. num_vec=DEPTH+5 -> clamped, exactly DEPTH compares. start during RUN is ignored.
- Reset/abort mid-run: assert reset low at compare 5 -> all outputs 0 immediately, state IDLE. abort at compare 5 -> IDLE with pass_cnt=5 held. A new start reruns correctly using the retained table.
